neuron_mac_unit: RTL and testbench

//  Parametrised single-neuron engine. Takes D streamed (x, weight) fixed-point pairs over a

---
 rtl/neuron_mac_unit.sv | 150 +++++++++++++++
 tb/tb_neuron_mac_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC: bias + sum of D (x*weight)>>>Q terms, saturated to N bits, then step/ReLU.
// Latency: result valid on the 2nd edge after the edge accepting beat D (D+2 cycles with in_valid held).
// Backpressure: in_ready low outside ACCUM; result held with o_out_valid until i_out_ready.
module neuron_mac_unit #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int D = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [N-1:0] i_bias,
    input  logic         i_mode,
    input  logic         i_clear,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_weight,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [N-1:0] o_data_out,
    output logic         o_busy
);
    // Guard bits cover D full-scale terms plus the bias, so the accumulator never wraps.
    localparam int ACC_W = 2*N - Q + $clog2(D+1) + 1;
    localparam int CNT_W = $clog2(D+1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [N-1:0] ONE_Q = N'(1) << Q;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACT, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_mode;
    logic                    r_out_valid;
    logic [N-1:0]            r_data_out;

    logic signed [2*N-1:0]   w_prod;
    logic signed [2*N-1:0]   w_prod_sh;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic [N-1:0]            w_sat;
    logic [N-1:0]            w_act;
    logic                    w_accum_open;
    logic                    w_beat;

    // Full-precision product, shifted back to Q format (floor toward -inf), then fitted to the accumulator.
    assign w_prod     = (2*N)'($signed(i_x)) * (2*N)'($signed(i_weight));
    assign w_prod_sh  = w_prod >>> Q;
    assign w_term     = ACC_W'(w_prod_sh);
    assign w_bias_ext = ACC_W'($signed(i_bias));

    // ACCUM stays open until all D beats are in; the extra ACCUM cycle with cnt==D lets acc settle.
    assign w_accum_open = (r_state == S_ACCUM) && (r_cnt != CNT_LAST);
    assign w_beat       = w_accum_open && i_in_valid;

    assign o_in_ready  = w_accum_open;
    assign o_out_valid = r_out_valid;
    assign o_data_out  = r_data_out;
    assign o_busy      = (r_state != S_IDLE);

    // Clamp the accumulator into the N-bit signed range.
    always_comb begin
        w_sat = r_acc[N-1:0];
        if (r_acc > SAT_MAX) begin
            w_sat = {1'b0, {(N-1){1'b1}}};
        end else if (r_acc < SAT_MIN) begin
            w_sat = {1'b1, {(N-1){1'b0}}};
        end
    end

    // Activation: ReLU passes non-negative values, step emits 1.0 for non-negative sums.
    always_comb begin
        w_act = '0;
        if (r_mode) begin
            w_act = w_sat[N-1] ? '0 : w_sat;
        end else begin
            w_act = w_sat[N-1] ? '0 : ONE_Q;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear forces IDLE over every other input.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_ACCUM;
            S_ACCUM: if (r_cnt == CNT_LAST) w_next_state = S_ACT;
            S_ACT:   w_next_state = S_DONE;
            S_DONE:  if (i_out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (i_clear) begin
            w_next_state = S_IDLE;
        end
    end

    // Datapath: bias/mode capture, accumulation, activation and output handshake.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else if (i_clear) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_acc  <= w_bias_ext;
                        r_cnt  <= '0;
                        r_mode <= i_mode;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc <= r_acc + w_term;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACT: begin
                    r_data_out  <= w_act;
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_unit.sv
module tb_neuron_mac_unit;
    localparam int N = 16;
    localparam int Q = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, start, mode, clear, in_valid, in_ready;
    logic         out_valid, out_ready, busy;
    logic [N-1:0] bias, x, w, data_out;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] bx [D];
    logic [N-1:0] bw [D];
    int           bgap [D];

    always #5 clk = ~clk;

    neuron_mac_unit #(.N(N), .Q(Q), .D(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_bias(bias), .i_mode(mode),
        .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_x(x),
        .i_weight(w), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_data_out(data_out), .o_busy(busy)
    );

    // Reference: real-valued fixed-point sum with floor division, clamp, activation.
    function automatic logic [N-1:0] model(input logic [N-1:0] b, input logic m);
        longint acc;
        longint p;
        acc = longint'($signed(b));
        for (int i = 0; i < D; i++) begin
            p = longint'($signed(bx[i])) * longint'($signed(bw[i]));
            acc = acc + (p >>> Q);
        end
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (m) return (acc < 0) ? 16'h0000 : 16'(acc);
        return (acc >= 0) ? 16'h0100 : 16'h0000;
    endfunction

    task automatic set_beats(input logic [N-1:0] xv, input logic [N-1:0] wv);
        for (int i = 0; i < D; i++) begin
            bx[i] = xv; bw[i] = wv; bgap[i] = 0;
        end
    endtask

    // Drives one evaluation from IDLE and waits (bounded) for out_valid.
    task automatic run_eval(input logic [N-1:0] b, input logic m,
                            output logic [N-1:0] res, output int lat);
        start = 1'b1; bias = b; mode = m;
        @(posedge clk); #1;
        start = 1'b0; bias = 16'($urandom); mode = 1'($urandom);
        lat = 0;
        for (int i = 0; i < D; i++) begin
            for (int g = 0; g < bgap[i]; g++) begin
                in_valid = 1'b0; x = 16'($urandom); w = 16'($urandom);
                @(posedge clk); #1; lat++;
            end
            in_valid = 1'b1; x = bx[i]; w = bw[i];
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        res = data_out;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_relu_basic();
        logic [N-1:0] res; int lat;
        set_beats(16'h0100, 16'h0080);
        run_eval(16'h0000, 1'b1, res, lat);
        n_vec++; if (res !== 16'h0200) begin n_err++; $display("FAIL relu_basic_data got=%h exp=0200", res); end
        n_vec++; if (lat !== D + 2) begin n_err++; $display("FAIL relu_basic_latency got=%0d exp=%0d", lat, D + 2); end
        drain();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL relu_basic_drain_valid got=%b exp=0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL relu_basic_drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_step_neg_bias();
        logic [N-1:0] res; int lat;
        set_beats(16'h0100, 16'h0080);
        run_eval(16'h0000, 1'b0, res, lat); drain();
        n_vec++; if (res !== 16'h0100) begin n_err++; $display("FAIL step_basic got=%h exp=0100", res); end
        run_eval(16'hFD00, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h0000) begin n_err++; $display("FAIL neg_bias_relu got=%h exp=0000", res); end
        run_eval(16'hFD00, 1'b0, res, lat); drain();
        n_vec++; if (res !== 16'h0000) begin n_err++; $display("FAIL neg_bias_step got=%h exp=0000", res); end
    endtask

    task automatic test_saturation();
        logic [N-1:0] res; int lat;
        set_beats(16'h7FFF, 16'h7FFF);
        run_eval(16'h0000, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos_relu got=%h exp=7fff", res); end
        set_beats(16'h7FFF, 16'h8000);
        run_eval(16'h0000, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h0000) begin n_err++; $display("FAIL sat_neg_relu got=%h exp=0000", res); end
        run_eval(16'h0000, 1'b0, res, lat); drain();
        n_vec++; if (res !== 16'h0000) begin n_err++; $display("FAIL sat_neg_step got=%h exp=0000", res); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] res; int lat;
        set_beats(16'h0100, 16'h0080);
        run_eval(16'h0000, 1'b1, res, lat);
        n_vec++; if (res !== 16'h0200) begin n_err++; $display("FAIL bp_data got=%h exp=0200", res); end
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", k, out_valid); end
            n_vec++; if (data_out !== 16'h0200) begin n_err++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=0200", k, data_out); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
        end
        // start still high while DONE exits: not accepted that cycle, accepted the next.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_exit_start_ignored got=%b exp=0", busy); end
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_held_start_accepted got=%b exp=1", busy); end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        bgap[1] = 1; bgap[2] = 1; bgap[3] = 1;
        run_eval(16'h0000, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h0200) begin n_err++; $display("FAIL gap_data got=%h exp=0200", res); end
        n_vec++; if (lat !== D + 5) begin n_err++; $display("FAIL gap_latency got=%0d exp=%0d", lat, D + 5); end
        set_beats(16'h0100, 16'h0080);
    endtask

    task automatic test_clear();
        logic [N-1:0] res; int lat;
        start = 1'b1; bias = 16'h0500; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; x = 16'h0100; w = 16'h0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0; in_valid = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_busy got=%b exp=0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clear_out_valid got=%b exp=0", out_valid); end
        in_valid = 1'b1; x = 16'h7FFF; w = 16'h7FFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_beats(16'h0100, 16'h0080);
        run_eval(16'h0000, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h0200) begin n_err++; $display("FAIL clear_rerun_data got=%h exp=0200", res); end
        n_vec++; if (lat !== D + 2) begin n_err++; $display("FAIL clear_rerun_latency got=%0d exp=%0d", lat, D + 2); end
    endtask

    task automatic test_rst_mid();
        logic [N-1:0] res; int lat;
        start = 1'b1; bias = 16'h0000; mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; x = 16'h0100; w = 16'h0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready got=%b exp=0", in_ready); end
        n_vec++; if (data_out !== 16'h0000) begin n_err++; $display("FAIL rst_mid_data_out got=%h exp=0000", data_out); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
        #2; rst = 1'b1;
        @(posedge clk); #1;
        run_eval(16'h0000, 1'b1, res, lat); drain();
        n_vec++; if (res !== 16'h0200) begin n_err++; $display("FAIL rst_rerun_data got=%h exp=0200", res); end
    endtask

    task automatic test_random();
        logic [N-1:0] res, exp_res, b; logic m; int lat, gaps;
        for (int t = 0; t < 40; t++) begin
            gaps = 0;
            for (int i = 0; i < D; i++) begin
                if (t % 2 == 0) begin
                    bx[i] = 16'($urandom_range(0, 2047)) - 16'd1024;
                    bw[i] = 16'($urandom_range(0, 511)) - 16'd256;
                end else begin
                    bx[i] = 16'($urandom); bw[i] = 16'($urandom);
                end
                bgap[i] = $urandom_range(0, 2);
                gaps += bgap[i];
            end
            b = (t % 2 == 0) ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom);
            m = 1'($urandom);
            exp_res = model(b, m);
            run_eval(b, m, res, lat);
            n_vec++; if (res !== exp_res) begin n_err++; $display("FAIL rand_data t=%0d got=%h exp=%h", t, res, exp_res); end
            n_vec++; if (lat !== D + 2 + gaps) begin n_err++; $display("FAIL rand_latency t=%0d got=%0d exp=%0d", t, lat, D + 2 + gaps); end
            drain();
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_drain t=%0d got=%b exp=0", t, out_valid); end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; bias = '0; mode = 1'b0; clear = 1'b0;
        in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b0;
        set_beats(16'h0100, 16'h0080);
        test_reset();
        test_relu_basic();
        test_step_neg_bias();
        test_saturation();
        test_backpressure();
        test_clear();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
